// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU: FETCH/DECODE/IMM/EXEC/WB with memory wait and timeout.
// Optional HALT state for opcode 0xF is enabled by defining CS_HALT_EN.
module control_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OT_W = 3,
  parameter int WAIT_MAX = 15,
  parameter logic [2**OPCODE_W-1:0] TWO_WORD_MASK = 'h0002
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [OPCODE_W-1:0] cs_opcode,
  input  logic                mem_rdy,
  output logic [ALU_OT_W-1:0] cs_alu_ot,
  output logic                cs_ins_load,
  output logic                cs_imm_load,
  output logic                cs_op1_load,
  output logic                cs_op2_load,
  output logic                cs_pc_load,
  output logic                cs_pc_inc,
  output logic                cs_reg_load,
  output logic                cs_timeout,
  output logic [2:0]          cs_state
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_IMM    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [OPCODE_W-1:0] r_op;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_next;
  logic                w_wait;
  logic                w_timeout;
  logic                w_in_alu;
  logic                w_in_two;
  logic                w_in_exec;
  logic                w_in_halt;
  logic                w_op_alu;
  logic [ALU_OT_W-1:0] w_alu;

  function automatic logic f_is_alu(input logic [OPCODE_W-1:0] op);
    return (op >= OPCODE_W'(2)) && (op <= OPCODE_W'(7));
  endfunction

  assign w_in_alu  = f_is_alu(cs_opcode);
  // Immediate selection only applies to the defined opcode range.
  assign w_in_two  = TWO_WORD_MASK[cs_opcode]
                     && (cs_opcode < OPCODE_W'(8));
  assign w_in_exec = (cs_opcode == '0) || w_in_alu;
`ifdef CS_HALT_EN
  assign w_in_halt = (cs_opcode == OPCODE_W'(15));
`else
  assign w_in_halt = 1'b0;
`endif

  assign w_op_alu  = f_is_alu(r_op);
  assign w_alu     = w_op_alu ? ALU_OT_W'(r_op) : '0;

  assign w_wait    = ((r_state == S_FETCH) || (r_state == S_IMM))
                     && !mem_rdy;
  assign w_timeout = w_wait && (r_cnt == CW'(WAIT_MAX));

  always_comb begin
    w_next = S_RESET;
    if (en) begin
      case (r_state)
        S_RESET:  w_next = S_FETCH;
        S_FETCH:  w_next = mem_rdy ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (w_in_two)       w_next = S_IMM;
          else if (w_in_exec) w_next = S_EXEC;
          else if (w_in_halt) w_next = S_HALT;
          else                w_next = S_FETCH;
        end
        S_IMM: begin
          if (mem_rdy)        w_next = S_EXEC;
          else if (w_timeout) w_next = S_FETCH;
          else                w_next = S_IMM;
        end
        S_EXEC:   w_next = S_WB;
        S_WB:     w_next = S_FETCH;
`ifdef CS_HALT_EN
        S_HALT:   w_next = S_HALT;
`endif
        default:  w_next = S_RESET;
      endcase
    end
  end

  // Any cycle that is not a plain wait (advance, timeout, other state) clears it.
  always_comb begin
    w_cnt_next = '0;
    if (en && w_wait && !w_timeout) w_cnt_next = r_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (en && (r_state == S_DECODE)) r_op <= cs_opcode;
    end
  end

  always_comb begin
    cs_alu_ot   = '0;
    cs_ins_load = 1'b0;
    cs_imm_load = 1'b0;
    cs_op1_load = 1'b0;
    cs_op2_load = 1'b0;
    cs_pc_load  = 1'b0;
    cs_pc_inc   = 1'b0;
    cs_reg_load = 1'b0;
    cs_timeout  = 1'b0;
    if (en) begin
      case (r_state)
        S_FETCH: begin
          cs_pc_load  = 1'b1;
          cs_ins_load = mem_rdy;
          cs_timeout  = w_timeout;
        end
        S_DECODE: begin
          cs_pc_inc   = 1'b1;
          cs_op1_load = w_in_alu;
        end
        S_IMM: begin
          cs_pc_load  = 1'b1;
          cs_imm_load = mem_rdy;
          cs_pc_inc   = mem_rdy;
          cs_timeout  = w_timeout;
        end
        S_EXEC: begin
          cs_alu_ot   = w_alu;
          cs_op2_load = (r_op == '0) || w_op_alu;
        end
        S_WB: begin
          cs_alu_ot   = w_alu;
          cs_reg_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cs_state = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed tables, async reset case and
// random instruction streams expanded into per-cycle expected strobes.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mem_rdy;
  logic [3:0] cs_opcode;
  logic [2:0] cs_alu_ot;
  logic       cs_ins_load, cs_imm_load, cs_op1_load, cs_op2_load;
  logic       cs_pc_load, cs_pc_inc, cs_reg_load, cs_timeout;
  logic [2:0] cs_state;
  logic [13:0] w_got;

  control_sequencer dut (
    .clk(clk), .rst(rst), .en(en),
    .cs_opcode(cs_opcode), .mem_rdy(mem_rdy),
    .cs_alu_ot(cs_alu_ot),
    .cs_ins_load(cs_ins_load), .cs_imm_load(cs_imm_load),
    .cs_op1_load(cs_op1_load), .cs_op2_load(cs_op2_load),
    .cs_pc_load(cs_pc_load), .cs_pc_inc(cs_pc_inc),
    .cs_reg_load(cs_reg_load), .cs_timeout(cs_timeout),
    .cs_state(cs_state)
  );

  always #5 clk = ~clk;

  assign w_got = {cs_alu_ot, cs_ins_load, cs_imm_load, cs_op1_load,
                  cs_op2_load, cs_pc_load, cs_pc_inc, cs_reg_load,
                  cs_timeout, cs_state};

  localparam logic [6:0] INS = 7'b1000000;
  localparam logic [6:0] IMM = 7'b0100000;
  localparam logic [6:0] OP1 = 7'b0010000;
  localparam logic [6:0] OP2 = 7'b0001000;
  localparam logic [6:0] PCL = 7'b0000100;
  localparam logic [6:0] PCI = 7'b0000010;
  localparam logic [6:0] REG = 7'b0000001;
  localparam logic [6:0] NON = 7'b0000000;

  typedef struct {
    logic        en;
    logic        rdy;
    logic [3:0]  op;
    logic [13:0] exp;
    string       name;
  } vec_t;

  vec_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [13:0] ex(input logic [2:0] st,
                                     input logic [2:0] alu,
                                     input logic [6:0] s,
                                     input logic to);
    return {alu, s, to, st};
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic push(input logic e, input logic r, input logic [3:0] op,
                      input logic [13:0] x, input string nm);
    vec_t v;
    v.en = e; v.rdy = r; v.op = op; v.exp = x; v.name = nm;
    q.push_back(v);
  endtask

  task automatic check(input string nm, input logic [13:0] got,
                       input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // One instruction as seen from the bus: fw wait cycles before the
  // instruction word, iw wait cycles before the immediate word.
  task automatic add_instr(input logic [3:0] op, input int fw, input int iw);
    logic alu_op, two, exe;
    logic [2:0] a;
    alu_op = (op >= 4'd2) && (op <= 4'd7);
    two    = (op == 4'd1);
    exe    = two || (op == 4'd0) || alu_op;
    a      = alu_op ? op[2:0] : 3'd0;
    for (int k = 0; k < fw; k++) push(1, 0, rop(), ex(1, 0, PCL, 0), "fetch_wait");
    push(1, 1, rop(), ex(1, 0, PCL | INS, 0), "fetch");
    push(1, rbit(), op, ex(2, 0, PCI | (alu_op ? OP1 : NON), 0), "decode");
    if (two) begin
      for (int k = 0; k < iw; k++) push(1, 0, rop(), ex(3, 0, PCL, 0), "imm_wait");
      push(1, 1, rop(), ex(3, 0, PCL | IMM | PCI, 0), "imm");
    end
    if (exe) begin
      push(1, rbit(), rop(), ex(4, a, two ? NON : OP2, 0), "exec");
      push(1, rbit(), rop(), ex(5, a, REG, 0), "wb");
    end
  endtask

  task automatic play();
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      @(negedge clk);
      en = v.en; mem_rdy = v.rdy; cs_opcode = v.op;
      #2;
      check(v.name, w_got, v.exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mem_rdy = 1'b0; cs_opcode = 4'd0;
    #3;
    check("reset_state", w_got, 14'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("reset_release", w_got, 14'd0);

    add_instr(4'd0, 0, 0);
    add_instr(4'd1, 0, 3);
    add_instr(4'd2, 1, 0);
    add_instr(4'd8, 0, 0);
`ifndef CS_HALT_EN
    add_instr(4'd15, 0, 0);
`endif
    // enable dropped in DECODE abandons the ADD
    push(1, 1, rop(), ex(1, 0, PCL | INS, 0), "fetch");
    push(0, 1, 4'd2, ex(2, 0, NON, 0), "en_low");
    push(1, 1, rop(), ex(0, 0, NON, 0), "en_reset");
    add_instr(4'd3, 0, 0);
    // FETCH timeout twice back to back proves the counter restarts
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 15; k++) push(1, 0, rop(), ex(1, 0, PCL, 0), "fetch_wait");
      push(1, 0, rop(), ex(1, 0, PCL, 1), "fetch_timeout");
    end
    add_instr(4'd0, 15, 0);
    // IMM timeout abandons MVI without PC increment
    push(1, 1, rop(), ex(1, 0, PCL | INS, 0), "fetch");
    push(1, 1, 4'd1, ex(2, 0, PCI, 0), "decode");
    for (int k = 0; k < 15; k++) push(1, 0, rop(), ex(3, 0, PCL, 0), "imm_wait");
    push(1, 0, rop(), ex(3, 0, PCL, 1), "imm_timeout");
    add_instr(4'd1, 0, 15);
    play();

    // async reset in the middle of EXEC
    push(1, 1, rop(), ex(1, 0, PCL | INS, 0), "fetch");
    push(1, 1, 4'd0, ex(2, 0, PCI, 0), "decode");
    play();
    @(negedge clk);
    mem_rdy = 1'b1; cs_opcode = rop();
    #1;
    check("exec_mov", w_got, ex(4, 0, OP2, 0));
    #1 rst = 1'b1;
    #1;
    check("rst_async", w_got, 14'd0);
    @(posedge clk);
    #1;
    check("rst_held", w_got, 14'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_release2", w_got, 14'd0);
    add_instr(4'd2, 0, 0);
    play();

`ifdef CS_HALT_EN
    push(1, 1, rop(), ex(1, 0, PCL | INS, 0), "fetch");
    push(1, 1, 4'd15, ex(2, 0, PCI, 0), "decode_halt");
    for (int k = 0; k < 20; k++) push(1, rbit(), rop(), ex(6, 0, NON, 0), "halt");
    push(0, 1, rop(), ex(6, 0, NON, 0), "halt_en_low");
    push(1, 1, rop(), ex(0, 0, NON, 0), "halt_reset");
    add_instr(4'd0, 0, 0);
    play();
`endif

    for (int n = 0; n < 200; n++) begin
`ifdef CS_HALT_EN
      add_instr(4'($urandom_range(0, 14)), $urandom_range(0, 3), $urandom_range(0, 3));
`else
      add_instr(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
`endif
    end
    play();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
